// File: rtl/int_source.sv
// int_source: interrupt generator/responder for the CPU interrupt input.
// Optional random gap extension via INT_SOURCE_LFSR_EN.
module int_source #(
   parameter logic [31:0] ACK_ADDR    = 32'h0000_7F20,
   parameter int unsigned MIN_GAP     = 16,
   parameter logic [7:0]  GAP_MASK    = 8'h3F,
   parameter int unsigned TIMEOUT     = 1024,
   parameter int unsigned HOLD_CYCLES = 2,
   parameter logic [31:0] SEED        = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        pulse_mode,
   input  logic [31:0] m_int_addr,
   input  logic [3:0]  m_int_byteen,
   output logic        interrupt,
   output logic        busy,
   output logic        err_timeout,
   output logic        err_spurious,
   output logic [15:0] irq_count,
   output logic [15:0] ack_count,
   output logic [15:0] ack_latency
);

   typedef enum logic [2:0] {
      IDLE,
      GAP,
      ASSERT,
      WAIT_ACK,
      HOLD
   } state_t;

   localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
   localparam logic [15:0] SAT       = 16'hFFFF;

   state_t      state;
   state_t      nxt_state;
   logic [15:0] cnt;
   logic [15:0] nxt_cnt;
   logic [15:0] lat;
   logic [15:0] nxt_lat;
   logic        mode_q;
   logic        nxt_mode;
   logic        nxt_int;
   logic        nxt_eto;
   logic        nxt_esp;
   logic [15:0] nxt_irq;
   logic [15:0] nxt_ack;
   logic [15:0] nxt_alat;
   logic        gap_enter;
   logic        ack;
   logic [15:0] gap_len;
   logic [15:0] gap_init;
   logic        unused_bits;

   // Acknowledge is a write of any width to the ack word.
   assign ack = (m_int_addr[31:2] == ACK_ADDR[31:2]) &&
                (m_int_byteen != 4'h0);

`ifdef INT_SOURCE_LFSR_EN
   logic [31:0] lfsr;
   logic [31:0] lfsr_step;

   assign lfsr_step = {1'b0, lfsr[31:1]} ^
                      (lfsr[0] ? 32'h8020_0003 : 32'h0000_0000);
   assign gap_len   = 16'(MIN_GAP) + {8'h00, lfsr[7:0] & GAP_MASK};
   assign unused_bits = ^m_int_addr[1:0];

   // Galois LFSR, advanced once per GAP entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr <= SEED;
      end else if (gap_enter) begin
         lfsr <= lfsr_step;
      end
   end
`else
   assign gap_len     = 16'(MIN_GAP);
   assign unused_bits = ^{m_int_addr[1:0], SEED, GAP_MASK, gap_enter};
`endif

   assign gap_init = gap_len - 16'd1;
   assign busy     = (state != IDLE);

   // Next-state and next-value logic for FSM and datapath.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_lat   = lat;
      nxt_mode  = mode_q;
      nxt_int   = interrupt;
      nxt_eto   = err_timeout;
      nxt_esp   = err_spurious;
      nxt_irq   = irq_count;
      nxt_ack   = ack_count;
      nxt_alat  = ack_latency;
      gap_enter = 1'b0;
      unique case (state)
         IDLE: begin
            if (ack) begin
               nxt_esp = 1'b1;
            end
            if (enable) begin
               nxt_state = GAP;
               nxt_cnt   = gap_init;
               gap_enter = 1'b1;
            end
         end
         GAP: begin
            if (ack) begin
               nxt_esp = 1'b1;
            end
            if (!enable) begin
               nxt_state = IDLE;
            end else if (cnt == 16'd0) begin
               nxt_state = ASSERT;
               nxt_int   = 1'b1;
               nxt_lat   = 16'd0;
               nxt_mode  = pulse_mode;
               if (irq_count != SAT) begin
                  nxt_irq = irq_count + 16'd1;
               end
            end else begin
               nxt_cnt = cnt - 16'd1;
            end
         end
         ASSERT, WAIT_ACK: begin
            nxt_lat = lat + 16'd1;
            if (ack) begin
               nxt_state = HOLD;
               nxt_cnt   = HOLD_INIT;
               nxt_int   = 1'b0;
               nxt_alat  = lat + 16'd1;
               if (ack_count != SAT) begin
                  nxt_ack = ack_count + 16'd1;
               end
            end else if (lat == TO_LAST) begin
               nxt_state = HOLD;
               nxt_cnt   = HOLD_INIT;
               nxt_int   = 1'b0;
               nxt_eto   = 1'b1;
            end else if (state == ASSERT && mode_q) begin
               nxt_state = WAIT_ACK;
               nxt_int   = 1'b0;
            end
         end
         HOLD: begin
            if (ack) begin
               nxt_esp = 1'b1;
            end
            if (cnt == 16'd0) begin
               if (enable) begin
                  nxt_state = GAP;
                  nxt_cnt   = gap_init;
                  gap_enter = 1'b1;
               end else begin
                  nxt_state = IDLE;
               end
            end else begin
               nxt_cnt = cnt - 16'd1;
            end
         end
         default: begin
            nxt_state = IDLE;
            nxt_int   = 1'b0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= 16'd0;
         lat          <= 16'd0;
         mode_q       <= 1'b0;
         interrupt    <= 1'b0;
         err_timeout  <= 1'b0;
         err_spurious <= 1'b0;
         irq_count    <= 16'd0;
         ack_count    <= 16'd0;
         ack_latency  <= 16'd0;
      end else begin
         state        <= nxt_state;
         cnt          <= nxt_cnt;
         lat          <= nxt_lat;
         mode_q       <= nxt_mode;
         interrupt    <= nxt_int;
         err_timeout  <= nxt_eto;
         err_spurious <= nxt_esp;
         irq_count    <= nxt_irq;
         ack_count    <= nxt_ack;
         ack_latency  <= nxt_alat;
      end
   end

endmodule

// File: tb/tb_int_source.sv
// tb_int_source: directed and random checks of int_source
// against a timestamp-based reference model.
module tb_int_source;

   localparam int MIN_GAP = 16;
   localparam int TIMEOUT = 1024;
   localparam int HOLD    = 2;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        pulse_mode;
   logic [31:0] m_int_addr;
   logic [3:0]  m_int_byteen;
   logic        interrupt;
   logic        busy;
   logic        err_timeout;
   logic        err_spurious;
   logic [15:0] irq_count;
   logic [15:0] ack_count;
   logic [15:0] ack_latency;

   int n_cmp;
   int n_bad;

   int_source dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .pulse_mode   (pulse_mode),
      .m_int_addr   (m_int_addr),
      .m_int_byteen (m_int_byteen),
      .interrupt    (interrupt),
      .busy         (busy),
      .err_timeout  (err_timeout),
      .err_spurious (err_spurious),
      .irq_count    (irq_count),
      .ack_count    (ack_count),
      .ack_latency  (ack_latency)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: phase 0 idle, 1 waiting for rise, 2 outstanding, 3 hold.
   longint m_t;
   int     m_ph;
   longint m_rise_at;
   longint m_rise;
   longint m_hold_end;
   logic   m_pm;
   logic   m_int;
   logic   m_eto;
   logic   m_esp;
   int     m_irq;
   int     m_ack;
   int     m_alat;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ph   = 0;
      m_int  = 1'b0;
      m_eto  = 1'b0;
      m_esp  = 1'b0;
      m_irq  = 0;
      m_ack  = 0;
      m_alat = 0;
      m_pm   = 1'b0;
   endtask

   task automatic model_edge(input logic en, input logic pm,
                             input logic [31:0] addr,
                             input logic [3:0] be);
      bit a;
      m_t++;
      a = ((addr >> 2) == (32'h7F20 >> 2)) && (be != 4'h0);
      case (m_ph)
         0: begin
            if (a) m_esp = 1'b1;
            if (en) begin
               m_ph      = 1;
               m_rise_at = m_t + MIN_GAP;
            end
         end
         1: begin
            if (a) m_esp = 1'b1;
            if (!en) begin
               m_ph = 0;
            end else if (m_t == m_rise_at) begin
               m_ph   = 2;
               m_rise = m_t;
               m_int  = 1'b1;
               m_pm   = pm;
               if (m_irq < 65535) m_irq++;
            end
         end
         2: begin
            if (a) begin
               m_int      = 1'b0;
               m_alat     = int'(m_t - m_rise);
               m_ph       = 3;
               m_hold_end = m_t + HOLD;
               if (m_ack < 65535) m_ack++;
            end else if (m_t - m_rise == TIMEOUT) begin
               m_eto      = 1'b1;
               m_int      = 1'b0;
               m_ph       = 3;
               m_hold_end = m_t + HOLD;
            end else if (m_pm && m_t == m_rise + 1) begin
               m_int = 1'b0;
            end
         end
         default: begin
            if (a) m_esp = 1'b1;
            if (m_t == m_hold_end) begin
               if (en) begin
                  m_ph      = 1;
                  m_rise_at = m_t + MIN_GAP;
               end else begin
                  m_ph = 0;
               end
            end
         end
      endcase
   endtask

   task automatic compare_all();
      check("interrupt", {31'd0, interrupt}, {31'd0, m_int});
      check("busy", {31'd0, busy}, {31'd0, m_ph != 0});
      check("err_timeout", {31'd0, err_timeout}, {31'd0, m_eto});
      check("err_spurious", {31'd0, err_spurious}, {31'd0, m_esp});
      check("irq_count", {16'd0, irq_count}, m_irq);
      check("ack_count", {16'd0, ack_count}, m_ack);
      check("ack_latency", {16'd0, ack_latency}, m_alat);
   endtask

   // One clock: drive inputs, model the edge, check after negedge.
   task automatic step(input logic en, input logic pm,
                       input logic [31:0] addr, input logic [3:0] be);
      enable       = en;
      pulse_mode   = pm;
      m_int_addr   = addr;
      m_int_byteen = be;
      @(posedge clk);
      model_edge(en, pm, addr, be);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle_steps(input int n, input logic en,
                             input logic pm);
      for (int i = 0; i < n; i++) step(en, pm, 32'h0, 4'h0);
   endtask

   task automatic ack_step(input logic en);
      step(en, 1'b0, 32'h0000_7F20, 4'hF);
   endtask

   task automatic wait_rise(input logic pm);
      int k;
      k = 0;
      while (interrupt !== 1'b1 && k < 200) begin
         step(1'b1, pm, 32'h0, 4'h0);
         k++;
      end
      check("rise_within_bound", {31'd0, interrupt}, 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int r;
      logic [31:0] a;
      logic [3:0]  b;
      n_cmp        = 0;
      n_bad        = 0;
      m_t          = 0;
      enable       = 1'b0;
      pulse_mode   = 1'b0;
      m_int_addr   = 32'h0;
      m_int_byteen = 4'h0;
      reset        = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      reset = 1'b0;

      // Basic level mode
      idle_steps(16, 1'b1, 1'b0);
      check("pre_rise", {31'd0, interrupt}, 32'd0);
      idle_steps(1, 1'b1, 1'b0);
      check("rise_e17", {31'd0, interrupt}, 32'd1);
      idle_steps(4, 1'b1, 1'b0);
      ack_step(1'b1);
      check("lat5", {16'd0, ack_latency}, 32'd5);
      check("irq1", {16'd0, irq_count}, 32'd1);
      check("ack1", {16'd0, ack_count}, 32'd1);
      check("fall", {31'd0, interrupt}, 32'd0);
      idle_steps(17, 1'b1, 1'b0);
      check("no_rise_a17", {31'd0, interrupt}, 32'd0);
      idle_steps(1, 1'b1, 1'b0);
      check("rise_a18", {31'd0, interrupt}, 32'd1);

      // Address filter
      step(1'b1, 1'b0, 32'h0000_7F24, 4'hF);
      step(1'b1, 1'b0, 32'h0000_7F20, 4'h0);
      check("filter_held", {31'd0, interrupt}, 32'd1);
      step(1'b1, 1'b0, 32'h0000_7F23, 4'b0001);
      check("lat3_7f23", {16'd0, ack_latency}, 32'd3);
      check("no_spur", {31'd0, err_spurious}, 32'd0);

      // Pulse mode
      wait_rise(1'b1);
      idle_steps(1, 1'b1, 1'b1);
      check("pulse_fall", {31'd0, interrupt}, 32'd0);
      idle_steps(8, 1'b1, 1'b1);
      ack_step(1'b1);
      check("pulse_ack", {16'd0, ack_count}, 32'd3);
      check("pulse_lat10", {16'd0, ack_latency}, 32'd10);
      check("pulse_no_spur", {31'd0, err_spurious}, 32'd0);

      // Enable drop during ASSERT keeps the interrupt
      wait_rise(1'b0);
      idle_steps(20, 1'b0, 1'b0);
      check("held_no_en", {31'd0, interrupt}, 32'd1);
      ack_step(1'b0);
      idle_steps(3, 1'b0, 1'b0);
      check("idle_after", {31'd0, busy}, 32'd0);

      // Enable drop mid-GAP
      idle_steps(5, 1'b1, 1'b0);
      idle_steps(1, 1'b0, 1'b0);
      check("gap_abort", {31'd0, busy}, 32'd0);
      idle_steps(20, 1'b0, 1'b0);
      check("gap_no_irq", {31'd0, interrupt}, 32'd0);

      // Spurious ack in GAP
      idle_steps(3, 1'b1, 1'b0);
      ack_step(1'b1);
      check("spur_gap", {31'd0, err_spurious}, 32'd1);

      // Timeout, sticky across later good acks
      wait_rise(1'b0);
      idle_steps(TIMEOUT - 1, 1'b1, 1'b0);
      check("pre_timeout", {31'd0, interrupt}, 32'd1);
      idle_steps(1, 1'b1, 1'b0);
      check("timeout_fall", {31'd0, interrupt}, 32'd0);
      check("timeout_flag", {31'd0, err_timeout}, 32'd1);
      wait_rise(1'b0);
      ack_step(1'b1);
      check("timeout_sticky", {31'd0, err_timeout}, 32'd1);

      // Ack on the timeout edge wins
      do_reset();
      wait_rise(1'b0);
      idle_steps(TIMEOUT - 1, 1'b1, 1'b0);
      ack_step(1'b1);
      check("edge_ack_lat", {16'd0, ack_latency}, 32'd1024);
      check("edge_ack_noerr", {31'd0, err_timeout}, 32'd0);

      // Async reset while interrupt high
      wait_rise(1'b0);
      #2;
      reset = 1'b1;
      #1;
      check("async_int", {31'd0, interrupt}, 32'd0);
      check("async_irq", {16'd0, irq_count}, 32'd0);
      check("async_ack", {16'd0, ack_count}, 32'd0);
      check("async_busy", {31'd0, busy}, 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      // Random traffic
      for (int i = 0; i < 20000; i++) begin
         r = $urandom_range(0, 19);
         a = 32'h0;
         b = 4'h0;
         if (r == 0) begin
            a = 32'h0000_7F20 | ($urandom & 32'h3);
            b = 4'($urandom);
         end else if (r == 1) begin
            a = 32'h0000_7F24;
            b = 4'hF;
         end else if (r == 2) begin
            a = $urandom;
            b = 4'($urandom);
         end
         step($urandom_range(0, 9) != 0, 1'($urandom), a, b);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/int_source.md
Name: int_source

Overview:
- External-interrupt responder/generator for the CPU's `interrupt` input.
- Schedules interrupt requests, drives the `interrupt` line, and waits for the CPU's acknowledge write.
- The acknowledge write arrives on the m_int_addr / m_int_byteen interrupt-response bus; the block then deasserts `interrupt` and schedules the next request.
- Instantiated beside the timers at system top; also used as the bench-side interrupt model.

Parameters:
- ACK_ADDR, 32'h0000_7F20, word address of the interrupt-acknowledge write (bits [1:0] ignored).
- MIN_GAP, 16, minimum cycles between the end of HOLD and the next interrupt rise (must be >= 1).
- GAP_MASK, 8'h3F, mask applied to LFSR bits for the random extra gap (used only when the optional feature is compiled in).
- TIMEOUT, 1024, maximum cycles from interrupt rise to acknowledge.
- HOLD_CYCLES, 2, cycles `interrupt` stays low after acknowledge or timeout (must be >= 1).
- SEED, 32'h0000_0001, LFSR reset value (must be nonzero).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  allow new interrupts to be scheduled.
- pulse_mode  in  1  0 = level held until acknowledge; 1 = single-cycle pulse, acknowledge still expected.
- m_int_addr  in  32  interrupt-response write address from the CPU.
- m_int_byteen  in  4  interrupt-response byte enables; any nonzero value marks a write.
- interrupt  out  1  interrupt request to the CPU (registered).
- busy  out  1  high whenever state != IDLE.
- err_timeout  out  1  sticky: an acknowledge missed TIMEOUT.
- err_spurious  out  1  sticky: an acknowledge arrived while none was outstanding.
- irq_count  out  16  interrupts issued, saturating at 16'hFFFF.
- ack_count  out  16  acknowledges accepted, saturating at 16'hFFFF.
- ack_latency  out  16  clock edges from interrupt rise to acknowledge, for the last accepted acknowledge.

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE; the LFSR loads SEED.
  - All outputs are 0, and all counters are 0.
- Acknowledge condition: ack = (m_int_addr[31:2] == ACK_ADDR[31:2]) && (m_int_byteen != 0), sampled at each rising edge.
- Gap length:
  - gap_len = MIN_GAP (+ random term, see Optional Feature).
  - It is computed when GAP is entered; the LFSR advances once per GAP entry.
- IDLE:
  - When enable = 1, go to GAP with cnt <= gap_len-1.
  - An ack in IDLE sets err_spurious.
- GAP:
  - cnt decrements each cycle.
  - If enable = 0, go to IDLE on the next edge, with no interrupt.
  - When cnt == 0, go to ASSERT: interrupt <= 1, irq_count++, lat <= 0, and pulse_mode is latched into mode_q.
  - The interrupt rises exactly gap_len edges after the edge entering GAP.
  - An ack in GAP sets err_spurious.
- ASSERT / WAIT_ACK:
  - lat increments each cycle; enable is ignored, so an outstanding interrupt is never truncated.
  - mode_q = 1: interrupt drops after one cycle and the state moves to WAIT_ACK.
  - mode_q = 0: interrupt is held high in ASSERT.
  - An ack in either state is accepted: interrupt <= 0, ack_count++, ack_latency <= lat+1, then go to HOLD.
  - An ack on the same edge as the interrupt-rise edge is not accepted (it counts as a GAP ack, i.e. spurious).
  - If lat == TIMEOUT-1 with no ack: err_timeout <= 1, interrupt <= 0, go to HOLD, ack_latency unchanged.
  - An ack on the timeout edge wins: it is treated as accepted and no error is raised.
- HOLD:
  - interrupt = 0 for HOLD_CYCLES cycles.
  - Then go to GAP (new gap_len) if enable = 1, else IDLE.
  - An ack in HOLD sets err_spurious.
- The error flags are cleared only by reset.
- The counters saturate rather than wrap.
- A reset during ASSERT drops interrupt immediately (asynchronously).

Optional Feature:
- Macro INT_SOURCE_LFSR_EN.
- Defined:
  - gap_len = MIN_GAP + (lfsr[7:0] & GAP_MASK).
  - The 32-bit Galois LFSR uses mask 32'h8020_0003 and shifts right once per GAP entry.
- Undefined:
  - The LFSR logic is absent and gap_len = MIN_GAP always.
  - SEED and GAP_MASK are unused.

Test Plan (macro undefined, defaults):
- Basic: reset, enable = 1 at edge E, pulse_mode = 0 → interrupt rises at edge E+17; ack 5 edges after the rise → interrupt falls, ack_latency = 5, irq_count = ack_count = 1, next rise 2+16 edges after the ack edge.
- Pulse mode: pulse_mode = 1 → interrupt high exactly one cycle; ack 10 edges after the rise → ack_count = 1, ack_latency = 10, err_spurious = 0.
- Timeout: no ack → interrupt falls 1024 edges after the rise, err_timeout = 1 and stays 1 across subsequent good acks; ack on exactly the 1024th edge → accepted, err_timeout = 0, ack_latency = 1024.
- Spurious / address filter:
  - ack during GAP → err_spurious = 1.
  - Write to 32'h7F24, or to 32'h7F20 with byteen = 0, while outstanding → ignored.
  - Address 32'h7F23 with byteen = 4'b0001 → accepted.
- Enable / reset: deassert enable mid-GAP → IDLE, no interrupt, busy = 0; deassert during ASSERT → interrupt held until ack; async reset while interrupt = 1 → interrupt = 0 before the next clk edge, counters = 0.
- Saturation: force 65536 handshakes with MIN_GAP = 1, HOLD_CYCLES = 1 → irq_count = ack_count = 16'hFFFF.
